uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter: LSB first, 1 start bit, optional parity, 1 or 2 stop bits.
- Timed from the shared 16x oversampling tick, so each bit lasts exactly 16 `tick_16x` pulses.
- Sits beside `uart_rx` on the same baud generator and drives the FTDI RX line.
- Takes one byte per request from the host logic using a start/busy/done handshake.

Parameters:
- PARITY_EN, 0: 1 inserts a parity bit after bit 7.
- PARITY_ODD, 0: parity sense when PARITY_EN=1. 0 = even, 1 = odd.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2; any other value is treated as 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick_16x  input  1  single-clk pulse at 16x baud rate
- tx_start  input  1  request to send tx_data; sampled every clk
- tx_data  input  8  byte to send; captured on acceptance
- tx_out  output  1  serial line; idle level is high
- tx_busy  output  1  high from acceptance until the frame ends
- tx_done  output  1  one-clk pulse when the last stop bit completes

Behaviour:
- All outputs are registered.
- Reset values: `tx_out`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, counters=0, shift register=0.
- Reset applied mid-frame aborts the frame. `tx_out` returns to 1 on that edge and no `tx_done` is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_out`=1.
  - `tx_start` is sampled on every clk, independent of `tick_16x`.
  - When `tx_start`=1 and `tx_busy`=0 on a clk edge, that edge does all of the following: captures `tx_data` into the shift register, clears the parity accumulator, sets `tick_count`=0, sets `bit_index`=0, sets `tx_busy`=1, sets `tx_out`=0, and enters START.
- Bit timing:
  - `tick_count` advances only on `tick_16x`.
  - A bit ends on the `tick_16x` at which `tick_count`==15. That tick resets the counter to 0 and drives the next bit's `tx_out` value.
  - The first bit after acceptance therefore lasts 15 to 16 tick periods, depending on tick phase. Every later bit is exactly 16 tick periods.
- START: at the end of the bit, drive data bit 0 and go to DATA.
- DATA:
  - At the end of each bit, XOR the current bit into the parity accumulator.
  - If `bit_index`<7: increment `bit_index` and drive the next data bit, LSB first.
  - If `bit_index`==7: go to PARITY and drive the parity bit when PARITY_EN=1; otherwise go to STOP and drive 1.
  - Parity bit value = XOR of the 8 data bits, XOR PARITY_ODD.
- PARITY: at the end of the bit, go to STOP and drive 1.
- STOP:
  - A stop-bit counter counts the completed stop bits.
  - When it reaches STOP_BITS, on that same tick edge: return to IDLE, set `tx_busy`=0, pulse `tx_done`=1 for exactly one clk, and keep `tx_out`=1.
- Frame length in ticks = 16 × (10 + PARITY_EN + (STOP_BITS==2)).
- `tx_start` while `tx_busy`=1 is ignored and is not queued. This includes the clk edge that ends the frame.
- `tx_start` on the clk after `tx_done` is accepted, giving back-to-back frames with no extra idle gap.
- `tx_data` changes after acceptance do not affect the frame in flight.
- A held-high `tx_start` sends the byte repeatedly, one frame after another.
- `tick_16x` arriving on the acceptance edge is not counted toward the start bit.

Test Plan:
- Defaults, send 0x55 → `tx_out` shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 16 ticks. `tx_busy` stays high for the frame; one `tx_done` pulse after 160 ticks.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 → parity bit 0. Repeat with PARITY_ODD=1 → parity bit 1. Repeat with 0x07 even parity → parity bit 1. Frame is 176 ticks.
- STOP_BITS=2, send 0x00 → eight 0 data bits, then 32 ticks of high line before `tx_done`. Frame is 176 ticks.
- Send 0x3C, then pulse `tx_start` with `tx_data`=0xFF mid-frame and on the `tx_done` edge → both requests ignored; exactly one frame (0x3C) is sent.
- Hold `tx_start` high with 0x81 then 0x42 → two contiguous frames, no idle gap, two `tx_done` pulses 160 ticks apart.
- Assert `rst` during data bit 3 of 0xF0 → next clk `tx_out`=1, `tx_busy`=0, no `tx_done`. A following send of 0x12 transmits correctly.
- Loopback `tx_out` into `uart_rx`, send 0x00, 0xFF, 0x5A → `uart_rx` reports the same bytes with one `rx_done` each.

Source files
------------

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the UART transmitter.
//   tx_start : request to send tx_data (sampled every clk)
//   tx_data  : byte to send, captured when the request is accepted
//   tx_busy  : high from acceptance until the frame ends
//   tx_done  : one-clk pulse when the last stop bit completes
// master = host logic, slave = uart_tx.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8-bit asynchronous serial transmitter: LSB first, one start bit, optional
// parity bit, one or two stop bits. Every bit lasts 16 tick_16x pulses.
//   clk      : system clock
//   rst      : synchronous, active-high reset (aborts any frame in flight)
//   tick_16x : single-clk pulse at 16x the baud rate
//   tx_out   : serial line, idles high
//   bus      : start/data/busy/done handshake (uart_tx_if.slave)
// All outputs are registered.
module uart_tx #(
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16x,
  output logic       tx_out,
  uart_tx_if.slave   bus
);

  localparam int unsigned TICK_W   = 4;
  localparam int unsigned BIT_W    = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TICK_MAX = 15;
  localparam int unsigned BIT_MAX  = DATA_W - 1;
  // Anything other than 2 stop bits falls back to 1.
  localparam int unsigned STOP_N   = (STOP_BITS == 2) ? 2 : 1;
  localparam logic        PAR_EN   = (PARITY_EN != 0);
  localparam logic        PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_count;
  logic [BIT_W-1:0]    bit_index;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity_acc;
  logic                stop_count;
  logic                busy_q;
  logic                done_q;
  logic                bit_end;

  // Current bit finishes on the tick that sees the last count value.
  assign bit_end = tick_16x && (tick_count == TICK_W'(TICK_MAX));

  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

  // Frame sequencer; the bit being sent is always shift_reg[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_out     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_count <= '0;
      bit_index  <= '0;
      shift_reg  <= '0;
      parity_acc <= 1'b0;
      stop_count <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Bit timer runs only while a frame is in flight.
      if ((state != S_IDLE) && tick_16x) begin
        tick_count <= bit_end ? '0 : tick_count + TICK_W'(1);
      end

      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (bus.tx_start && !busy_q) begin
            shift_reg  <= bus.tx_data;
            parity_acc <= 1'b0;
            tick_count <= '0;
            bit_index  <= '0;
            stop_count <= 1'b0;
            busy_q     <= 1'b1;
            tx_out     <= 1'b0;
            state      <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_out <= shift_reg[0];
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            parity_acc <= parity_acc ^ shift_reg[0];
            if (bit_index != BIT_W'(BIT_MAX)) begin
              bit_index <= bit_index + BIT_W'(1);
              shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
              tx_out    <= shift_reg[1];
            end else if (PAR_EN) begin
              // Fold in bit 7 directly; parity_acc only updates on this edge.
              tx_out <= parity_acc ^ shift_reg[0] ^ PAR_ODD;
              state  <= S_PARITY;
            end else begin
              tx_out <= 1'b1;
              state  <= S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx_out <= 1'b1;
            state  <= S_STOP;
          end
        end

        S_STOP: begin
          tx_out <= 1'b1;
          if (bit_end) begin
            if (stop_count == 1'(STOP_N - 1)) begin
              stop_count <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= S_IDLE;
            end else begin
              stop_count <= stop_count + 1'b1;
            end
          end
        end

        default: begin
          tx_out <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five instances with different framing parameters share
// clk, rst and tick. A tick-counting line model checks tx_out/tx_busy/tx_done
// every cycle; a mid-bit decoder recovers each byte and compares it against
// the scoreboard queue filled by the stimulus tasks.
module tb_uart_tx;

  localparam int unsigned N_DUT = 5;
  localparam int unsigned TDIV  = 3;
  localparam int          NV    = 12;
  localparam int          BUDGET = 1200;

  // dut0 default, dut1 even parity, dut2 odd parity, dut3 two stops, dut4 STOP_BITS=3
  localparam logic [N_DUT-1:0] PE_M  = 5'b00110;
  localparam logic [N_DUT-1:0] PO_M  = 5'b00100;
  localparam logic [N_DUT-1:0] SB2_M = 5'b01000;
  localparam logic [N_DUT-1:0] SB3_M = 5'b10000;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         ticks;
    int         par;   // -1: frame has no parity bit
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [N_DUT-1:0] start_v = '0;
  logic [7:0]       data_v [N_DUT];
  logic [N_DUT-1:0] out_v;
  logic [N_DUT-1:0] busy_v;
  logic [N_DUT-1:0] done_v;

  exp_t exp_q [$];

  logic        m_busy     [N_DUT];
  logic        m_done     [N_DUT];
  int          m_nt       [N_DUT];
  int          m_nbits    [N_DUT];
  logic [11:0] m_bits     [N_DUT];
  logic [11:0] dec        [N_DUT];
  int          samp_idx   [N_DUT];
  int          meas       [N_DUT];
  int          last_ticks [N_DUT];
  logic        last_par   [N_DUT];
  logic        prev_busy  [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tick = (ph == TDIV - 1);
      ph   = (ph + 1) % TDIV;
    end
  end

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    uart_tx_if bus ();
    assign bus.tx_start = start_v[g];
    assign bus.tx_data  = data_v[g];
    assign busy_v[g]    = bus.tx_busy;
    assign done_v[g]    = bus.tx_done;

    uart_tx #(
      .PARITY_EN  (32'(PE_M[g])),
      .PARITY_ODD (32'(PO_M[g])),
      .STOP_BITS  (SB2_M[g] ? 2 : (SB3_M[g] ? 3 : 1))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_16x (tick),
      .tx_out   (out_v[g]),
      .bus      (bus.slave)
    );
  end

  function automatic void chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, id, act, exp, $time);
    end
  endfunction

  // Remove the pending expectation of a frame aborted by reset.
  task automatic drop(int i);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (32'(exp_q[k].id) == 32'(i)) begin
        exp_q.delete(k);
        break;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      for (int i = 0; i < N_DUT; i++) begin
        samp_idx[i] = -1;
        if (prev_busy[i]) begin
          if (tick) meas[i]++;
        end else begin
          meas[i] = 0;
        end
        if (rst) begin
          if (m_busy[i]) drop(i);
          m_busy[i] = 1'b0;
          m_done[i] = 1'b0;
        end else if (m_busy[i]) begin
          m_done[i] = 1'b0;
          if (tick) begin
            m_nt[i]++;
            if (m_nt[i] == 16 * m_nbits[i]) begin
              m_busy[i] = 1'b0;
              m_done[i] = 1'b1;
            end else if (m_nt[i] % 16 == 8) begin
              samp_idx[i] = m_nt[i] / 16;
            end
          end
        end else begin
          m_done[i] = 1'b0;
          if (start_v[i]) begin
            m_bits[i]      = '1;
            m_bits[i][0]   = 1'b0;
            m_bits[i][8:1] = data_v[i];
            if (PE_M[i]) m_bits[i][9] = (^data_v[i]) ^ PO_M[i];
            m_nbits[i] = 10 + int'(PE_M[i]) + int'(SB2_M[i]);
            m_nt[i]    = 0;
            m_busy[i]  = 1'b1;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
        logic line;
        exp_t e;
        line = m_busy[i] ? m_bits[i][m_nt[i] / 16] : 1'b1;
        chk("tx_out", i, 32'(out_v[i]), 32'(line));
        chk("tx_busy", i, 32'(busy_v[i]), 32'(m_busy[i]));
        chk("tx_done", i, 32'(done_v[i]), 32'(m_done[i]));
        if (samp_idx[i] >= 0) dec[i][samp_idx[i]] = out_v[i];
        if (done_v[i] === 1'b1) begin
          last_ticks[i] = meas[i];
          last_par[i]   = dec[i][9];
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_frame", i, 32'(exp_q.size()), 32'(1));
          end else begin
            e = exp_q.pop_front();
            chk("sb_dut_id", i, 32'(e.id), 32'(i));
            chk("rx_byte", i, 32'(dec[i][8:1]), 32'(e.data));
          end
        end
        prev_busy[i] = busy_v[i];
      end
    end
  endtask

  task automatic send(int i, logic [7:0] d);
    exp_q.push_back({3'(i), d});
    @(negedge clk);
    data_v[i]  = d;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    data_v[i]  = 8'($urandom);
  endtask

  // Returns at the negedge where tx_done is seen (or after the budget).
  task automatic wait_done(int i);
    int got;
    got = 0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (done_v[i] === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (got == 0) chk("done_within_budget", i, 32'(got), 32'(1));
  endtask

  task automatic run();
    vec_t vt [NV];
    vt[0]  = '{0, 8'h55, 160, -1};
    vt[1]  = '{1, 8'hA5, 176, 0};
    vt[2]  = '{2, 8'hA5, 176, 1};
    vt[3]  = '{1, 8'h07, 176, 1};
    vt[4]  = '{3, 8'h00, 176, -1};
    vt[5]  = '{4, 8'h3C, 160, -1};
    vt[6]  = '{0, 8'h00, 160, -1};
    vt[7]  = '{0, 8'hFF, 160, -1};
    vt[8]  = '{0, 8'h5A, 160, -1};
    vt[9]  = '{2, 8'h00, 176, 1};
    vt[10] = '{1, 8'hFF, 176, 0};
    vt[11] = '{3, 8'hFF, 176, -1};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      chk("reset_tx_out", i, 32'(out_v[i]), 32'(1));
      chk("reset_tx_busy", i, 32'(busy_v[i]), 32'(0));
      chk("reset_tx_done", i, 32'(done_v[i]), 32'(0));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      send(vt[v].id, vt[v].data);
      wait_done(vt[v].id);
      #1;
      chk("frame_ticks", vt[v].id, 32'(last_ticks[vt[v].id]), 32'(vt[v].ticks));
      if (vt[v].par >= 0)
        chk("parity_bit", vt[v].id, 32'(last_par[vt[v].id]), 32'(vt[v].par));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Requests while busy (mid-frame and on the done edge) are dropped.
    send(0, 8'h3C);
    repeat (200) @(negedge clk);
    data_v[0] = 8'hFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 0; k < BUDGET && m_busy[0] && m_nt[0] < 159; k++) @(negedge clk);
    start_v[0] = 1'b1;
    wait_done(0);
    start_v[0] = 1'b0;
    #1;
    chk("ignored_frame_ticks", 0, 32'(last_ticks[0]), 32'(160));
    repeat (40) @(negedge clk);
    chk("ignored_idle_busy", 0, 32'(busy_v[0]), 32'(0));

    // Held start: back-to-back frames, data change mid-frame picked up next.
    exp_q.push_back({3'd0, 8'h81});
    exp_q.push_back({3'd0, 8'h42});
    data_v[0]  = 8'h81;
    start_v[0] = 1'b1;
    repeat (50) @(negedge clk);
    data_v[0] = 8'h42;
    wait_done(0);
    #1;
    chk("held_frame1_ticks", 0, 32'(last_ticks[0]), 32'(160));
    wait_done(0);
    start_v[0] = 1'b0;
    #1;
    chk("held_frame2_ticks", 0, 32'(last_ticks[0]), 32'(160));
    repeat (10) @(negedge clk);

    // Reset during data bit 3 aborts the frame; next frame is clean.
    send(0, 8'hF0);
    for (int k = 0; k < BUDGET && m_nt[0] < 70; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx_out", 0, 32'(out_v[0]), 32'(1));
    chk("abort_tx_busy", 0, 32'(busy_v[0]), 32'(0));
    chk("abort_tx_done", 0, 32'(done_v[0]), 32'(0));
    repeat (5) @(negedge clk);
    send(0, 8'h12);
    wait_done(0);
    #1;
    chk("after_abort_ticks", 0, 32'(last_ticks[0]), 32'(160));

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      data_v[i]     = '0;
      m_busy[i]     = 1'b0;
      m_done[i]     = 1'b0;
      m_nt[i]       = 0;
      m_nbits[i]    = 10;
      m_bits[i]     = '1;
      dec[i]        = '0;
      samp_idx[i]   = -1;
      meas[i]       = 0;
      last_ticks[i] = 0;
      last_par[i]   = 1'b0;
      prev_busy[i]  = 1'b0;
    end
    fork
      monitor();
      run();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
